reg_writeback_ctrl: RTL and testbench
=====================================

Name: reg_writeback_ctrl

Overview:
Write-side controller for the 8-entry general register file. It accepts results from the ALU and the memory-load unit through valid/ready handshakes and buffers them in a small FIFO. It drives the register file's write data bus (bath_c) and its one-hot write strobes latch0..latch7. It also keeps a pending-write scoreboard that the issue logic queries with the same read addresses (aadr/badr) it presents to the register file.

Parameters:
DATA_W, `DATA_W from def.h (16), write-data width
DEPTH, 2, FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU result offered
alu_ready  out  1  ALU result accepted this edge when alu_valid=1
alu_cadr  in  4  ALU destination register
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load result offered
mem_ready  out  1  load result accepted this edge when mem_valid=1
mem_cadr  in  4  load destination register
mem_data  in  DATA_W  load data
wb_stall  in  1  freeze draining of the FIFO
issue_valid  in  1  instruction issued with a register destination
issue_cadr  in  4  destination of the issued instruction
aadr, badr  in  4 each  scoreboard query addresses
a_busy, b_busy  out  1 each  pending write exists for aadr/badr
bath_c  out  DATA_W  register-file write data
latch0..latch7  out  1 each  one-hot write strobes
bad_addr  out  1  sticky flag: a write or issue targeted register 8..15

Behaviour:
- Reset (async, rst=1): FIFO empty, count=0; bath_c=0; latch0..7=0; busy[7:0]=0; bad_addr=0. In-flight writes are discarded; no strobe is emitted after reset.
- Ready: mem_ready = (count<DEPTH). alu_ready = (count<DEPTH) && !mem_valid. Fixed priority: load over ALU. At most one push per cycle.
- Push: a handshake with cadr 0..7 pushes {cadr[2:0], data}. A handshake with cadr 8..15 completes but pushes nothing and sets bad_addr. bad_addr clears only on rst.
- Drain, each edge:
  - If FIFO is non-empty and wb_stall=0: pop the head. The output stage registers bath_c=data and asserts exactly the one latchN for the head's cadr.
  - Otherwise: all latchN=0 and bath_c holds its previous value.
  - Strobes are single-cycle pulses.
- Push and pop in the same cycle: count is unchanged. Pop-through of an entry pushed on the same edge is not allowed.
- Latency: accepted at edge N with FIFO empty and no stall → latchN/bath_c valid between edges N+1 and N+2 → register file captures at edge N+2.
- Order: writes leave in acceptance order. Two writes to the same register in flight: the later value wins.
- Scoreboard busy[7:0]:
  - issue_valid with issue_cadr<8 sets busy[issue_cadr].
  - issue_cadr>=8 sets bad_addr only.
  - A bit clears at the edge where its latchN is high, i.e. the register-file capture edge.
  - Set and clear of the same bit on the same edge: set wins.
- Query mapping: a_busy = busy[min(aadr,7)] and b_busy = busy[min(badr,7)]. Combinational, matching the register-file read mapping where addresses >=7 select gr7.
- A FIFO of count DEPTH with wb_stall=1 holds all entries; both ready outputs stay 0.

Decomposition:
- def.h gains: REG_NUM=8, RADR_W=4, and a one-hot decode macro or function for the 3-bit write address.
- Sub-module wb_fifo: parameterised DATA_W+3 wide, DEPTH deep. Ports: push, pop, full, empty, count, head. The controller instantiates wb_fifo and holds arbitration, the output stage, the scoreboard and bad_addr.

Test Plan:
1. Reset: pulse rst mid-stream with 2 entries queued → all latch=0, bath_c=0, a_busy=b_busy=0, bad_addr=0 immediately (asynchronous); no strobe after release.
2. Single write: alu cadr=3 data=16'h1234 accepted at edge N → latch3=1 only and bath_c=16'h1234 between N+1 and N+2; the attached register file reads gr3=16'h1234 after N+2.
3. Arbitration: alu (r1,16'hAAAA) and mem (r2,16'h5555) both valid → mem accepted and alu_ready=0 at N; alu accepted at N+1; latch2 pulses, then latch1 in the next cycle with matching data.
4. Backpressure: wb_stall=1, push r4=1, then r5=2 → ready outputs drop to 0 and a third offer (r6=3) is held; release stall → latch4, latch5, latch6 pulse on consecutive cycles in that order.
5. Scoreboard: issue r5 → b_busy=1 with badr=5 from the next edge; write r5 clears it at the latch5 capture edge; re-issue of r5 on that same edge keeps b_busy=1. aadr=12 reports busy[7].
6. Bad address: alu cadr=9 → alu_ready handshake completes, no latch pulses, bad_addr=1 and stays 1 until rst.

Source files
------------

// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared constants and helpers for the register-file write-back controller.
package reg_writeback_ctrl_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 2;
    localparam int REG_NUM    = 8;
    localparam int RADR_W     = 4;
    localparam int WADR_W     = 3;

    // Turns a 3-bit register-file write address into its one-hot strobe vector.
    function automatic logic [REG_NUM-1:0] wr_onehot(input logic [WADR_W-1:0] adr);
        logic [REG_NUM-1:0] r_vec;
        r_vec = {{(REG_NUM-1){1'b0}}, 1'b1} << adr;
        return r_vec;
    endfunction

endpackage

// File: rtl/reg_writeback_ctrl_wb_fifo.sv
// Small circular FIFO that buffers accepted write-backs ahead of the output stage.
module wb_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Pushes into a full FIFO and pops from an empty one are ignored so state never corrupts.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    // Storage array has no reset; the pointers alone decide which slots are live.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Write-side controller for the 8-entry register file: arbitrates ALU and load results,
// queues them, drives bath_c with one-hot latch strobes, and tracks pending writes.
module reg_writeback_ctrl
    import reg_writeback_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [RADR_W-1:0] alu_cadr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [RADR_W-1:0] mem_cadr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_stall,
    input  logic              issue_valid,
    input  logic [RADR_W-1:0] issue_cadr,
    input  logic [RADR_W-1:0] aadr,
    input  logic [RADR_W-1:0] badr,
    output logic              a_busy,
    output logic              b_busy,
    output logic [DATA_W-1:0] bath_c,
    output logic              latch0,
    output logic              latch1,
    output logic              latch2,
    output logic              latch3,
    output logic              latch4,
    output logic              latch5,
    output logic              latch6,
    output logic              latch7,
    output logic              bad_addr
);

    localparam int ENTRY_W = DATA_W + WADR_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    logic [ENTRY_W-1:0] w_head;
    logic               w_space;
    logic               w_mem_hs;
    logic               w_alu_hs;
    logic               w_hs;
    logic [RADR_W-1:0]  w_sel_cadr;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_push;
    logic               w_pop;
    logic               w_bad_push;
    logic               w_bad_issue;
    logic [WADR_W-1:0]  w_head_cadr;
    logic [DATA_W-1:0]  w_head_data;
    logic [REG_NUM-1:0] w_issue_set;
    logic [WADR_W-1:0]  w_a_idx;
    logic [WADR_W-1:0]  w_b_idx;

    logic [DATA_W-1:0]  r_bath_c;
    logic [REG_NUM-1:0] r_latch;
    logic [REG_NUM-1:0] r_busy;
    logic               r_bad_addr;

    // Full and count both describe occupancy; requiring both keeps ready low if they ever disagree.
    assign w_space   = !w_full && (w_count < CNT_W'(DEPTH));
    assign mem_ready = w_space;
    assign alu_ready = w_space && !mem_valid;

    assign w_mem_hs   = mem_valid && mem_ready;
    assign w_alu_hs   = alu_valid && alu_ready;
    assign w_hs       = w_mem_hs || w_alu_hs;
    assign w_sel_cadr = w_mem_hs ? mem_cadr : alu_cadr;
    assign w_sel_data = w_mem_hs ? mem_data : alu_data;

    // Destinations 8..15 complete the handshake but never enter the queue.
    assign w_push      = w_hs && !w_sel_cadr[RADR_W-1];
    assign w_bad_push  = w_hs && w_sel_cadr[RADR_W-1];
    assign w_bad_issue = issue_valid && issue_cadr[RADR_W-1];

    // Only entries present before the edge can drain, so a fresh push never pops through.
    assign w_pop = !w_empty && !wb_stall;

    assign w_head_cadr = w_head[ENTRY_W-1:DATA_W];
    assign w_head_data = w_head[DATA_W-1:0];

    assign w_issue_set = (issue_valid && !issue_cadr[RADR_W-1])
                       ? wr_onehot(issue_cadr[WADR_W-1:0]) : '0;

    wb_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .push_data({w_sel_cadr[WADR_W-1:0], w_sel_data}),
        .pop      (w_pop),
        .full     (w_full),
        .empty    (w_empty),
        .count    (w_count),
        .head     (w_head)
    );

    // Output stage: a pop produces a one-cycle strobe for the head's register; bath_c otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bath_c <= '0;
            r_latch  <= '0;
        end else if (w_pop) begin
            r_bath_c <= w_head_data;
            r_latch  <= wr_onehot(w_head_cadr);
        end else begin
            r_latch  <= '0;
        end
    end

    // Scoreboard: a bit clears on the edge the register file captures it; a new issue on that edge wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~r_latch) | w_issue_set;
        end
    end

    // Sticky out-of-range destination flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bad_addr <= 1'b0;
        end else if (w_bad_push || w_bad_issue) begin
            r_bad_addr <= 1'b1;
        end
    end

    // Read addresses 7..15 all alias gr7, so the query clamps the same way.
    assign w_a_idx = aadr[RADR_W-1] ? WADR_W'(REG_NUM-1) : aadr[WADR_W-1:0];
    assign w_b_idx = badr[RADR_W-1] ? WADR_W'(REG_NUM-1) : badr[WADR_W-1:0];
    assign a_busy  = r_busy[w_a_idx];
    assign b_busy  = r_busy[w_b_idx];

    assign bath_c   = r_bath_c;
    assign bad_addr = r_bad_addr;
    assign latch0   = r_latch[0];
    assign latch1   = r_latch[1];
    assign latch2   = r_latch[2];
    assign latch3   = r_latch[3];
    assign latch4   = r_latch[4];
    assign latch5   = r_latch[5];
    assign latch6   = r_latch[6];
    assign latch7   = r_latch[7];

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed, table-driven bench for reg_writeback_ctrl with a behavioural register file.
module tb_reg_writeback_ctrl;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_cadr;
    logic [15:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_cadr;
    logic [15:0] mem_data;
    logic        wb_stall;
    logic        issue_valid;
    logic [3:0]  issue_cadr;
    logic [3:0]  aadr;
    logic [3:0]  badr;
    logic        a_busy;
    logic        b_busy;
    logic [15:0] bath_c;
    logic        latch0, latch1, latch2, latch3, latch4, latch5, latch6, latch7;
    logic        bad_addr;
    logic [7:0]  latchVec;
    logic [15:0] gr [8];

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic        aluV;
        logic [3:0]  aluC;
        logic [15:0] aluD;
        logic        memV;
        logic [3:0]  memC;
        logic [15:0] memD;
        logic        stall;
        logic        issV;
        logic [3:0]  issC;
        logic [3:0]  aAdr;
        logic [3:0]  bAdr;
        logic        expAluRdy;
        logic        expMemRdy;
        logic        expA;
        logic        expB;
        logic [7:0]  expLatch;
        logic [15:0] expBath;
        logic        expBad;
    } vec_t;

    vec_t vecs[$];

    reg_writeback_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_cadr   (alu_cadr),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_cadr   (mem_cadr),
        .mem_data   (mem_data),
        .wb_stall   (wb_stall),
        .issue_valid(issue_valid),
        .issue_cadr (issue_cadr),
        .aadr       (aadr),
        .badr       (badr),
        .a_busy     (a_busy),
        .b_busy     (b_busy),
        .bath_c     (bath_c),
        .latch0     (latch0),
        .latch1     (latch1),
        .latch2     (latch2),
        .latch3     (latch3),
        .latch4     (latch4),
        .latch5     (latch5),
        .latch6     (latch6),
        .latch7     (latch7),
        .bad_addr   (bad_addr)
    );

    assign latchVec = {latch7, latch6, latch5, latch4, latch3, latch2, latch1, latch0};

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file stand-in: captures bath_c into the strobed register on the rising edge.
    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (latchVec[k]) gr[k] <= bath_c;
        end
    end

    function automatic vec_t mk(input logic aluV, input logic [3:0] aluC, input logic [15:0] aluD,
                                input logic memV, input logic [3:0] memC, input logic [15:0] memD,
                                input logic stall, input logic issV, input logic [3:0] issC,
                                input logic [3:0] aAdr, input logic [3:0] bAdr,
                                input logic eAluRdy, input logic eMemRdy, input logic eA, input logic eB,
                                input logic [7:0] eLatch, input logic [15:0] eBath, input logic eBad);
        vec_t v;
        v.aluV = aluV;   v.aluC = aluC;   v.aluD = aluD;
        v.memV = memV;   v.memC = memC;   v.memD = memD;
        v.stall = stall; v.issV = issV;   v.issC = issC;
        v.aAdr = aAdr;   v.bAdr = bAdr;
        v.expAluRdy = eAluRdy; v.expMemRdy = eMemRdy;
        v.expA = eA; v.expB = eB; v.expLatch = eLatch; v.expBath = eBath; v.expBad = eBad;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        alu_valid   = v.aluV;
        alu_cadr    = v.aluC;
        alu_data    = v.aluD;
        mem_valid   = v.memV;
        mem_cadr    = v.memC;
        mem_data    = v.memD;
        wb_stall    = v.stall;
        issue_valid = v.issV;
        issue_cadr  = v.issC;
        aadr        = v.aAdr;
        badr        = v.bAdr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic idleInputs();
        alu_valid = 0; alu_cadr = 0; alu_data = 0;
        mem_valid = 0; mem_cadr = 0; mem_data = 0;
        wb_stall = 0; issue_valid = 0; issue_cadr = 0;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) gr[k] = 16'h0000;
        idleInputs();
        aadr = 0;
        badr = 0;
        rst  = 1'b1;

        //           aluV C  D        memV C  D        st iV iC  a   b   aR mR A  B  latch  bath     bad
        vecs.push_back(mk(1, 3, 16'h1234, 0, 0, 16'h0000, 0, 0, 0, 0,  0,  1, 1, 0, 0, 8'h00, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0,  0,  1, 1, 0, 0, 8'h00, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0,  0,  1, 1, 0, 0, 8'h08, 16'h1234, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0,  0,  1, 1, 0, 0, 8'h00, 16'h1234, 0));
        vecs.push_back(mk(1, 1, 16'hAAAA, 1, 2, 16'h5555, 0, 0, 0, 0,  0,  0, 1, 0, 0, 8'h00, 16'h1234, 0));
        vecs.push_back(mk(1, 1, 16'hAAAA, 0, 0, 16'h0000, 0, 0, 0, 0,  0,  1, 1, 0, 0, 8'h00, 16'h1234, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0,  0,  1, 1, 0, 0, 8'h04, 16'h5555, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0,  0,  1, 1, 0, 0, 8'h02, 16'hAAAA, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0,  0,  1, 1, 0, 0, 8'h00, 16'hAAAA, 0));
        vecs.push_back(mk(1, 4, 16'h0001, 0, 0, 16'h0000, 1, 0, 0, 0,  0,  1, 1, 0, 0, 8'h00, 16'hAAAA, 0));
        vecs.push_back(mk(1, 5, 16'h0002, 0, 0, 16'h0000, 1, 0, 0, 0,  0,  1, 1, 0, 0, 8'h00, 16'hAAAA, 0));
        vecs.push_back(mk(1, 6, 16'h0003, 0, 0, 16'h0000, 1, 0, 0, 0,  0,  0, 0, 0, 0, 8'h00, 16'hAAAA, 0));
        vecs.push_back(mk(1, 6, 16'h0003, 0, 0, 16'h0000, 1, 0, 0, 0,  0,  0, 0, 0, 0, 8'h00, 16'hAAAA, 0));
        vecs.push_back(mk(1, 6, 16'h0003, 0, 0, 16'h0000, 0, 0, 0, 0,  0,  0, 0, 0, 0, 8'h00, 16'hAAAA, 0));
        vecs.push_back(mk(1, 6, 16'h0003, 0, 0, 16'h0000, 0, 0, 0, 0,  0,  1, 1, 0, 0, 8'h10, 16'h0001, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0,  0,  1, 1, 0, 0, 8'h20, 16'h0002, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0,  0,  1, 1, 0, 0, 8'h40, 16'h0003, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0,  0,  1, 1, 0, 0, 8'h00, 16'h0003, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 5, 12, 5,  1, 1, 0, 0, 8'h00, 16'h0003, 0));
        vecs.push_back(mk(1, 5, 16'h0BEE, 0, 0, 16'h0000, 0, 0, 0, 12, 5,  1, 1, 0, 1, 8'h00, 16'h0003, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 12, 5,  1, 1, 0, 1, 8'h00, 16'h0003, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 5, 12, 5,  1, 1, 0, 1, 8'h20, 16'h0BEE, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 7, 12, 5,  1, 1, 0, 1, 8'h00, 16'h0BEE, 0));
        vecs.push_back(mk(1, 5, 16'h0C0C, 0, 0, 16'h0000, 0, 0, 0, 12, 5,  1, 1, 1, 1, 8'h00, 16'h0BEE, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 12, 5,  1, 1, 1, 1, 8'h00, 16'h0BEE, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 12, 5,  1, 1, 1, 1, 8'h20, 16'h0C0C, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 12, 5,  1, 1, 1, 0, 8'h00, 16'h0C0C, 0));
        vecs.push_back(mk(1, 9, 16'hFFFF, 0, 0, 16'h0000, 0, 0, 0, 12, 5,  1, 1, 1, 0, 8'h00, 16'h0C0C, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 12, 5,  1, 1, 1, 0, 8'h00, 16'h0C0C, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 12, 5,  1, 1, 1, 0, 8'h00, 16'h0C0C, 1));

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset latch", 32'(latchVec), 32'h0);
        checkOutput("reset bath_c", 32'(bath_c), 32'h0);
        checkOutput("reset bad_addr", 32'(bad_addr), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].expAluRdy));
            checkOutput($sformatf("v%0d mem_ready", i), 32'(mem_ready), 32'(vecs[i].expMemRdy));
            checkOutput($sformatf("v%0d a_busy", i), 32'(a_busy), 32'(vecs[i].expA));
            checkOutput($sformatf("v%0d b_busy", i), 32'(b_busy), 32'(vecs[i].expB));
            checkOutput($sformatf("v%0d latch", i), 32'(latchVec), 32'(vecs[i].expLatch));
            checkOutput($sformatf("v%0d bath_c", i), 32'(bath_c), 32'(vecs[i].expBath));
            checkOutput($sformatf("v%0d bad_addr", i), 32'(bad_addr), 32'(vecs[i].expBad));
        end

        // Register file contents after every queued write has been captured.
        @(negedge clk);
        idleInputs();
        checkOutput("gr1", 32'(gr[1]), 32'h0000AAAA);
        checkOutput("gr2", 32'(gr[2]), 32'h00005555);
        checkOutput("gr3", 32'(gr[3]), 32'h00001234);
        checkOutput("gr4", 32'(gr[4]), 32'h00000001);
        checkOutput("gr5", 32'(gr[5]), 32'h00000C0C);
        checkOutput("gr6", 32'(gr[6]), 32'h00000003);

        // Queue two writes under stall with a pending issue, then reset mid-cycle.
        wb_stall = 1; alu_valid = 1; alu_cadr = 0; alu_data = 16'h1111;
        issue_valid = 1; issue_cadr = 2;
        @(negedge clk);
        alu_cadr = 1; alu_data = 16'h2222; issue_valid = 0;
        @(negedge clk);
        alu_valid = 0; aadr = 2; badr = 2;
        #1;
        checkOutput("pre-reset full", 32'(mem_ready), 32'h0);
        checkOutput("pre-reset busy", 32'(a_busy), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async latch", 32'(latchVec), 32'h0);
        checkOutput("async bath_c", 32'(bath_c), 32'h0);
        checkOutput("async a_busy", 32'(a_busy), 32'h0);
        checkOutput("async b_busy", 32'(b_busy), 32'h0);
        checkOutput("async bad_addr", 32'(bad_addr), 32'h0);
        checkOutput("async mem_ready", 32'(mem_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        wb_stall = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("post-reset latch c%0d", c), 32'(latchVec), 32'h0);
            checkOutput($sformatf("post-reset bath_c c%0d", c), 32'(bath_c), 32'h0);
        end

        // Out-of-range issue sets only the sticky flag.
        issue_valid = 1; issue_cadr = 10;
        @(negedge clk);
        issue_valid = 0;
        #1;
        checkOutput("issue bad_addr", 32'(bad_addr), 32'h1);
        checkOutput("issue no busy", 32'(b_busy), 32'h0);

        // Out-of-range load is accepted but never strobes.
        mem_valid = 1; mem_cadr = 8; mem_data = 16'hBEEF;
        #1;
        checkOutput("bad load ready", 32'(mem_ready), 32'h1);
        @(negedge clk);
        mem_valid = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("bad load latch c%0d", c), 32'(latchVec), 32'h0);
            checkOutput($sformatf("bad load sticky c%0d", c), 32'(bad_addr), 32'h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
